// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues req/ack reads at the current PC, holds the
// returned instruction for IF/ID and gates the PC write-enable.
module if_fetch_ctrl #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_write_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0] state;
    logic       flush_pending;

    // PC advances when ID takes the held instruction, or on any redirect once running.
    always_comb begin
        pc_write_o = ((state == HOLD) && !stall_i) || (flush_i && (state != IDLE));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= '0;
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A redirect this cycle means pc_i is stale; retry next cycle.
                    if (!flush_i) begin
                        imem_addr_o <= pc_i;
                        imem_req_o  <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        if (flush_i || flush_pending) begin
                            flush_pending <= 1'b0;
                            state         <= ISSUE;
                        end else begin
                            instr_o       <= imem_data_i;
                            instr_pc_o    <= imem_addr_o;
                            instr_valid_o <= 1'b1;
                            state         <= HOLD;
                        end
                    end else if (flush_i) begin
                        // The in-flight read is never cancelled; its data is dropped on ack.
                        flush_pending <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        instr_valid_o <= 1'b0;
                        instr_o       <= NOP_INSTR;
                        state         <= ISSUE;
                    end else if (!stall_i) begin
                        instr_valid_o <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed vector table, reset/idle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_if_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pc_write_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;

    int total = 0;
    int bad   = 0;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i), .pc_write_o(pc_write_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_data_i(imem_data_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_valid_o(instr_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          start, stall, flush, ack;
        logic [31:0] pc, data;
        bit          e_pw, e_req, e_valid, chk_instr;
        logic [31:0] e_addr, e_instr, e_ipc;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s, input logic [31:0] p, input bit st, input bit fl,
                         input bit ak, input logic [31:0] d);
        start_i = s; pc_i = p; stall_i = st; flush_i = fl; imem_ack_i = ak; imem_data_i = d;
    endtask

    // Reference model: tracks the fetch as a transaction (running / outstanding / held).
    bit          m_run, m_req, m_valid, m_disc;
    logic [31:0] m_addr, m_instr, m_ipc;

    task automatic model_reset();
        m_run = 0; m_req = 0; m_valid = 0; m_disc = 0;
        m_addr = '0; m_instr = '0; m_ipc = '0;
    endtask

    task automatic model_step();
        if (!m_run) begin
            m_run = start_i;
        end else if (m_valid) begin
            if (flush_i) begin
                m_valid = 0; m_instr = '0;
            end else if (!stall_i) begin
                m_valid = 0;
            end
        end else if (m_req) begin
            if (imem_ack_i) begin
                m_req = 0;
                if (flush_i || m_disc) m_disc = 0;
                else begin
                    m_valid = 1; m_instr = imem_data_i; m_ipc = m_addr;
                end
            end else if (flush_i) begin
                m_disc = 1;
            end
        end else if (!flush_i) begin
            m_req = 1; m_addr = pc_i;
        end
    endtask

    function automatic vec_t mk(bit s, logic [31:0] p, bit st, bit fl, bit ak, logic [31:0] d,
                                bit pw, bit rq, logic [31:0] ad, bit v, logic [31:0] ins,
                                logic [31:0] ipc, bit ci);
        vec_t r;
        r.start = s; r.pc = p; r.stall = st; r.flush = fl; r.ack = ak; r.data = d;
        r.e_pw = pw; r.e_req = rq; r.e_addr = ad; r.e_valid = v; r.e_instr = ins;
        r.e_ipc = ipc; r.chk_instr = ci;
        return r;
    endfunction

    initial begin
        bit          pw_exp;
        bit          run_seen;
        logic [31:0] seed_pc;

        tbl[0]  = mk(1, 32'h00, 0, 0, 0, 32'h0,        0, 0, 32'h00, 0, 32'h0,        32'h00, 1);
        tbl[1]  = mk(0, 32'h00, 0, 0, 0, 32'h0,        0, 0, 32'h00, 0, 32'h0,        32'h00, 1);
        tbl[2]  = mk(0, 32'h00, 0, 0, 1, 32'h8C010004, 0, 1, 32'h00, 0, 32'h0,        32'h00, 1);
        tbl[3]  = mk(0, 32'h00, 0, 0, 0, 32'h0,        1, 0, 32'h00, 1, 32'h8C010004, 32'h00, 1);
        tbl[4]  = mk(0, 32'h04, 0, 0, 0, 32'h0,        0, 0, 32'h00, 0, 32'h8C010004, 32'h00, 1);
        tbl[5]  = mk(0, 32'h04, 0, 0, 1, 32'h11111111, 0, 1, 32'h04, 0, 32'h8C010004, 32'h00, 1);
        for (int unsigned i = 6; i <= 9; i++)
            tbl[i] = mk(0, 32'h04, 1, 0, 0, 32'h0,     0, 0, 32'h04, 1, 32'h11111111, 32'h04, 1);
        tbl[10] = mk(0, 32'h04, 0, 0, 0, 32'h0,        1, 0, 32'h04, 1, 32'h11111111, 32'h04, 1);
        tbl[11] = mk(0, 32'h08, 0, 0, 0, 32'h0,        0, 0, 32'h04, 0, 32'h11111111, 32'h04, 1);
        tbl[12] = mk(0, 32'h40, 0, 1, 0, 32'h0,        1, 1, 32'h08, 0, 32'h11111111, 32'h04, 1);
        tbl[13] = mk(0, 32'h40, 0, 0, 0, 32'h0,        0, 1, 32'h08, 0, 32'h11111111, 32'h04, 1);
        tbl[14] = mk(0, 32'h40, 0, 0, 0, 32'h0,        0, 1, 32'h08, 0, 32'h11111111, 32'h04, 1);
        tbl[15] = mk(0, 32'h40, 0, 0, 1, 32'hDEADBEEF, 0, 1, 32'h08, 0, 32'h11111111, 32'h04, 1);
        tbl[16] = mk(0, 32'h40, 0, 0, 0, 32'h0,        0, 0, 32'h08, 0, 32'h0,        32'h04, 0);
        tbl[17] = mk(0, 32'h40, 0, 0, 1, 32'h22222222, 0, 1, 32'h40, 0, 32'h0,        32'h04, 0);
        tbl[18] = mk(0, 32'h40, 1, 1, 0, 32'h0,        1, 0, 32'h40, 1, 32'h22222222, 32'h40, 1);
        tbl[19] = mk(0, 32'h44, 0, 1, 0, 32'h0,        1, 0, 32'h40, 0, 32'h0,        32'h40, 1);
        tbl[20] = mk(0, 32'h48, 0, 0, 0, 32'h0,        0, 0, 32'h40, 0, 32'h0,        32'h40, 1);
        tbl[21] = mk(0, 32'h48, 0, 0, 0, 32'h0,        0, 1, 32'h48, 0, 32'h0,        32'h40, 1);

        // Reset state
        #12;
        chk("rst_req",   {31'b0, imem_req_o},    32'h0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o,                32'h0);
        chk("rst_pw",    {31'b0, pc_write_o},    32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Directed vector table: inputs driven 1 unit after the edge, checked 2 units later
        for (int unsigned i = 0; i < 22; i++) begin
            drive(tbl[i].start, tbl[i].pc, tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].data);
            #2;
            chk($sformatf("v%0d_pw", i),    {31'b0, pc_write_o},    {31'b0, tbl[i].e_pw});
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req_o},    {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr_o,            tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, tbl[i].e_valid});
            chk($sformatf("v%0d_ipc", i),   instr_pc_o,             tbl[i].e_ipc);
            if (tbl[i].chk_instr)
                chk($sformatf("v%0d_instr", i), instr_o, tbl[i].e_instr);
            @(posedge clk_i); #1;
        end

        // Asynchronous reset mid-WAIT, then a late ack while reset is held
        drive(0, 32'h100, 0, 0, 0, 32'h0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_req_o},    32'h0);
        chk("arst_addr",  imem_addr_o,            32'h0);
        chk("arst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("arst_pw",    {31'b0, pc_write_o},    32'h0);
        imem_ack_i = 1'b1; imem_data_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1 imem_ack_i = 1'b0;

        // Idle with start_i=0 for 10 cycles; flush/stall pulses must do nothing
        for (int unsigned c = 0; c < 10; c++) begin
            drive(0, 32'h100, c[0], (c % 3) == 0, c[1], 32'h12345678);
            #2;
            chk($sformatf("idle%0d_req", c),   {31'b0, imem_req_o},    32'h0);
            chk($sformatf("idle%0d_pw", c),    {31'b0, pc_write_o},    32'h0);
            chk($sformatf("idle%0d_valid", c), {31'b0, instr_valid_o}, 32'h0);
            @(posedge clk_i); #1;
        end

        // Restart fetch from pc_i
        drive(1, 32'h100, 0, 0, 0, 32'h0);
        @(posedge clk_i); #1 start_i = 1'b0;
        @(posedge clk_i); #2;
        chk("restart_req",  {31'b0, imem_req_o}, 32'h1);
        chk("restart_addr", imem_addr_o,         32'h100);

        // Randomized traffic against the reference model
        rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        model_reset();
        seed_pc = 32'h0;
        run_seen = 0;
        for (int unsigned c = 0; c < 3000; c++) begin
            if (pc_write_o) seed_pc = $urandom_range(0, 1) ? seed_pc + 32'd4 : {$urandom} & ~32'h3;
            drive($urandom_range(0, 3) != 0, seed_pc, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom);
            #2;
            pw_exp = (m_valid && !stall_i) || (flush_i && m_run);
            chk("rnd_pw",    {31'b0, pc_write_o},    {31'b0, pw_exp});
            chk("rnd_req",   {31'b0, imem_req_o},    {31'b0, m_req});
            chk("rnd_valid", {31'b0, instr_valid_o}, {31'b0, m_valid});
            if (m_req) chk("rnd_addr", imem_addr_o, m_addr);
            if (m_valid) begin
                chk("rnd_instr", instr_o,    m_instr);
                chk("rnd_ipc",   instr_pc_o, m_ipc);
                run_seen = 1;
            end
            model_step();
            @(posedge clk_i); #1;
        end
        if (!run_seen) chk("rnd_progress", 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller on the consumer side of the program counter register.
- Takes the current PC value, issues a request/acknowledge read to instruction memory, and holds the returned instruction for the IF/ID stage.
- Drives the PC write-enable, so the PC advances only after the ID stage has accepted an instruction or a branch redirect occurs.
- Sits between the PC register, the instruction memory port and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
NOP_INSTR, 32'h0000_0000, value of instr_o at reset and after discard

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  CPU run enable; sampled only in IDLE
pc_i  in  ADDR_W  current PC register output
stall_i  in  1  ID stage cannot accept an instruction this cycle
flush_i  in  1  one-cycle pulse: branch/jump taken, next-PC mux selects target this cycle
pc_write_o  out  1  write-enable to PC register (combinational)
imem_req_o  out  1  memory read request, held until acknowledged
imem_addr_o  out  ADDR_W  memory read address, stable while imem_req_o=1
imem_ack_i  in  1  memory returns imem_data_i this cycle
imem_data_i  in  DATA_W  instruction read data
instr_o  out  DATA_W  fetched instruction to IF/ID
instr_pc_o  out  ADDR_W  address of instr_o
instr_valid_o  out  1  instr_o is valid and offered to ID

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst_i=1, all state is held at reset values:
  - state=IDLE, flush_pending=0
  - imem_req_o=0, imem_addr_o=0
  - instr_o=NOP_INSTR, instr_pc_o=0, instr_valid_o=0
  - pc_write_o=0
- Reset mid-operation abandons any outstanding request. A late ack after reset is ignored, because ack is only honoured in WAIT.
- All outputs except pc_write_o are registered.
- pc_write_o is 1 in exactly two cases:
  - (state=HOLD and stall_i=0)
  - (flush_i=1 and state!=IDLE)
- States:
  - IDLE: all outputs idle. start_i=1 -> ISSUE. After leaving IDLE, start_i is ignored.
  - ISSUE: single cycle. Normally, at the clock edge imem_addr_o<=pc_i and imem_req_o<=1, then -> WAIT. If flush_i=1 this cycle, pc_i is stale: no request is issued and the state stays in ISSUE.
  - WAIT: imem_req_o and imem_addr_o are held until imem_ack_i=1.
    - On ack with no flush (flush_i=0 and flush_pending=0): instr_o<=imem_data_i, instr_pc_o<=imem_addr_o, instr_valid_o<=1, imem_req_o<=0, then -> HOLD.
    - On ack with flush_i=1 or flush_pending=1: data is discarded, imem_req_o<=0, flush_pending<=0, instr_valid_o stays 0, then -> ISSUE.
    - flush_i=1 without ack: flush_pending<=1 and stay in WAIT. The in-flight request is never cancelled.
  - HOLD: instr_valid_o=1 and instr_o is stable.
    - stall_i=0: ID accepts at the edge, the PC advances (pc_write_o=1), instr_valid_o<=0, then -> ISSUE.
    - stall_i=1: hold everything.
    - flush_i=1 has priority over stall_i: instr_valid_o<=0, instr_o<=NOP_INSTR, then -> ISSUE.
- Latency and throughput:
  - With memory ack in the first WAIT cycle and no stall, each instruction takes 3 cycles (ISSUE, WAIT, HOLD).
  - instr_valid_o rises on the edge after ack.
- Boundary cases:
  - A repeated flush while flush_pending=1 pulses pc_write_o again; flush_pending stays 1.
  - flush_i and stall_i are ignored in IDLE.
  - The address wraps naturally; the block does no PC arithmetic.

Test Plan:
1. Reset, then start_i=1 with pc_i=0x0 and memory acking 1 cycle after req with data 0x8C010004, stall_i=0 -> imem_addr_o=0x0; instr_o=0x8C010004, instr_pc_o=0x0, instr_valid_o=1 for 1 cycle; pc_write_o=1 in that HOLD cycle; next req carries pc_i=0x4.
2. Instruction in HOLD and stall_i=1 for 4 cycles -> instr_valid_o=1, instr_o unchanged and pc_write_o=0 for all 4 cycles; pc_write_o=1 in the cycle stall_i drops.
3. flush_i pulse in WAIT with ack 3 cycles later (data 0xDEADBEEF) -> pc_write_o=1 only in the flush cycle; data discarded (instr_valid_o stays 0); next request uses the new pc_i (branch target 0x40).
4. flush_i and stall_i both 1 in HOLD -> pc_write_o=1, instr_valid_o=0 and instr_o=0x0 next cycle, state ISSUE.
5. Assert rst_i asynchronously mid-WAIT, then deliver a late ack -> all outputs return to 0 immediately and the ack is ignored; after reset release and start_i=1, fetch restarts from pc_i.
6. start_i=0 after reset for 10 cycles -> imem_req_o=0, pc_write_o=0 throughout; flush_i pulses in that window have no effect.
